rocc_cmd_arbiter: RTL

// - Shares one RoCC accelerator port between NR_REQ requesters (issue-side RoCC FU front-ends).
// - Round-robin arbitration of the command channel, with the grant locked until the handshake completes.
// - In-order tag FIFO records which requester owns each response-bearing command (instr[ROCC_XD_BIT]=1).
// - Steers each accelerator response back to its owner. Responses to commands issued before a flush are drained and dropped.

---
 rtl/rocc_cmd_arbiter_pkg.sv | 25 ++
 rtl/rocc_cmd_arbiter_tag_fifo.sv | 62 ++++++
 rtl/rocc_cmd_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rocc_cmd_arbiter_pkg.sv
// Shared types for the RoCC command arbiter: command/response payloads
// and the per-command ownership tag held in the response tag FIFO.
package rocc_cmd_arbiter_pkg;

    // instr bit that marks a command as response-bearing (xd)
    localparam int unsigned ROCC_XD_BIT  = 14;
    // owner field width; supports up to 16 requesters
    localparam int unsigned ROCC_OWNER_W = 4;

    typedef struct packed {
        logic [63:0] cmd_rs1;
        logic [63:0] cmd_rs2;
        logic [31:0] cmd_instr;
    } rocc_cmd_t;

    typedef struct packed {
        logic [63:0] resp_data;
    } rocc_resp_t;

    typedef struct packed {
        logic [ROCC_OWNER_W-1:0] owner;
        logic                    discard;
    } rocc_tag_t;

endpackage

// File: rtl/rocc_cmd_arbiter_tag_fifo.sv
// In-order FIFO of ownership tags for outstanding response-bearing commands.
module rocc_tag_fifo
    import rocc_cmd_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  rocc_tag_t push_tag_i,
    input  logic      pop_i,
    input  logic      flush_mark_i,
    output rocc_tag_t head_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    rocc_tag_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_d    = push_i ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop_i  ? rd_q + PTR_W'(1) : rd_q;
        count_d = count_q;
        if (push_i && !pop_i)
            count_d = count_q + (PTR_W+1)'(1);
        else if (!push_i && pop_i)
            count_d = count_q - (PTR_W+1)'(1);
    end

    // Storage and pointer registers. Flush marks every slot: slots that are
    // free or being popped are never read before a push overwrites them, so
    // this equals marking only the entries that survive the pop. The pushed
    // tag carries its own discard bit and wins over the flush mark.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++)
                mem_q[k] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (flush_mark_i)
                for (int unsigned k = 0; k < DEPTH; k++)
                    mem_q[k].discard <= 1'b1;
            if (push_i)
                mem_q[wr_q] <= push_tag_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// Shares one RoCC accelerator port between NR_REQ requesters: round-robin
// command arbitration with grant lock, and in-order response steering.
module rocc_cmd_arbiter
    import rocc_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NR_REQ = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [NR_REQ-1:0]      req_valid_i,
    output logic [NR_REQ-1:0]      req_ready_o,
    input  rocc_cmd_t [NR_REQ-1:0] req_cmd_i,
    output rocc_cmd_t              rocc_cmd_o,
    output logic                   rocc_cmd_valid_o,
    input  logic                   rocc_cmd_ready_i,
    input  rocc_resp_t             rocc_resp_i,
    input  logic                   rocc_resp_valid_i,
    output logic                   rocc_resp_ready_o,
    output logic [NR_REQ-1:0]      resp_valid_o,
    output logic [63:0]            resp_data_o,
    input  logic [NR_REQ-1:0]      resp_ready_i,
    output logic                   busy_o,
    output logic                   spurious_resp_o
);

    localparam int unsigned IDX_W = $clog2(NR_REQ);

    logic [IDX_W-1:0]  rr_q, rr_d, lock_idx_q, lock_idx_d;
    logic              lock_q, lock_d;
    logic [NR_REQ-1:0] elig;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid, cmd_hs;
    int unsigned       cand, nxt;

    logic              tag_push, tag_pop, tag_empty, tag_full;
    rocc_tag_t         push_tag, head;

    // Eligibility: xd commands need a free tag slot (registered count only).
    always_comb begin
        for (int unsigned i = 0; i < NR_REQ; i++)
            elig[i] = req_valid_i[i] & (~req_cmd_i[i].cmd_instr[ROCC_XD_BIT] | ~tag_full);
    end

    // Grant selection: locked index, else first eligible from rr_q upward.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NR_REQ; i++) begin
                cand = 32'(rr_q) + i;
                if (cand >= NR_REQ)
                    cand = cand - NR_REQ;
                if (!gnt_valid && elig[IDX_W'(cand)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IDX_W'(cand);
                end
            end
        end
    end

    // Command channel drive and lock/round-robin next state.
    always_comb begin
        rocc_cmd_valid_o = gnt_valid;
        rocc_cmd_o       = req_cmd_i[gnt_idx];
        for (int unsigned i = 0; i < NR_REQ; i++)
            req_ready_o[i] = gnt_valid & rocc_cmd_ready_i & (gnt_idx == IDX_W'(i));
        cmd_hs   = gnt_valid & rocc_cmd_ready_i;
        tag_push = cmd_hs & rocc_cmd_o.cmd_instr[ROCC_XD_BIT];
        push_tag = '{owner: ROCC_OWNER_W'(gnt_idx), discard: flush_i};
        nxt      = 32'(gnt_idx) + 1;
        if (nxt >= NR_REQ)
            nxt = 0;
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (cmd_hs) begin
            lock_d = 1'b0;
            rr_d   = IDX_W'(nxt);
        end else if (gnt_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Response steering to the owner at the FIFO head; discarded/spurious dropped.
    always_comb begin
        resp_valid_o      = '0;
        rocc_resp_ready_o = 1'b1;
        tag_pop           = 1'b0;
        spurious_resp_o   = 1'b0;
        if (tag_empty) begin
            spurious_resp_o = rocc_resp_valid_i;
        end else if (head.discard) begin
            tag_pop = rocc_resp_valid_i;
        end else begin
            rocc_resp_ready_o = 1'b0;
            for (int unsigned i = 0; i < NR_REQ; i++) begin
                if (head.owner == ROCC_OWNER_W'(i)) begin
                    resp_valid_o[i]   = rocc_resp_valid_i;
                    rocc_resp_ready_o = resp_ready_i[i];
                end
            end
            tag_pop = rocc_resp_valid_i & rocc_resp_ready_o;
        end
    end

    assign resp_data_o = rocc_resp_i.resp_data;
    assign busy_o      = ~tag_empty;

    rocc_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (tag_push),
        .push_tag_i   (push_tag),
        .pop_i        (tag_pop),
        .flush_mark_i (flush_i),
        .head_o       (head),
        .empty_o      (tag_empty),
        .full_o       (tag_full)
    );

endmodule
